// File: rtl/sift_pkg.sv
// Shared definitions for the SIFT front-end pixel stream.
//   PIX_W      width of one grey-scale pixel
//   STREAM_W   width of the {valid, pixel} stream word
//   VALID_BIT  position of the valid flag (downstream line-buffer clock enable)
//   tx_state_t frame reader states
package sift_pkg;

  localparam int PIX_W     = 8;
  localparam int STREAM_W  = 9;
  localparam int VALID_BIT = 8;

  typedef enum logic [2:0] {
    IDLE,
    ACTIVE,
    HBLANK,
    FLUSH,
    DRAIN,
    DONE
  } tx_state_t;

endpackage

// File: rtl/pixel_stream_tx_if.sv
// Bus bundle of pixel_stream_tx: the synchronous RAM read port and the
// {valid, pixel} output stream with its line/frame markers.
//   omem_rd     RAM read strobe
//   omem_addr   RAM read address (ADDR_W bits)
//   imem_data   RAM read data, one cycle after the RAM samples omem_rd
//   oPixelData  {valid, pixel} stream word
//   oline_end   last valid word of a line
//   oframe_end  last valid word of the frame
// master: the frame reader. slave: RAM model plus stream consumer.
interface pixel_stream_tx_if #(
  parameter int ADDR_W = 19
);
  import sift_pkg::*;

  logic                omem_rd;
  logic [ADDR_W-1:0]   omem_addr;
  logic [PIX_W-1:0]    imem_data;
  logic [STREAM_W-1:0] oPixelData;
  logic                oline_end;
  logic                oframe_end;

  modport master (
    output omem_rd, omem_addr, oPixelData, oline_end, oframe_end,
    input  imem_data
  );

  modport slave (
    input  omem_rd, omem_addr, oPixelData, oline_end, oframe_end,
    output imem_data
  );

endinterface

// File: rtl/pixel_raster_cnt.sv
// Raster position counters for pixel_stream_tx.
// Holds the column, row and horizontal-blank counters and flags the last
// column, the last row (frame rows, or flush rows when flushMode is set)
// and the last blank cycle.
//   iclk, irst_n  clock, asynchronous active-low reset
//   clear         zero all counters (frame start)
//   colStep       advance column; wraps to 0 after the last column
//   rowStep       advance row and restart the blank count
//   rowClear      restart the row count (entering the flush lines)
//   blankStep     advance the blank count
//   flushMode     compare the row against FLUSH_LINES instead of HEIGHT
//   lastCol, lastRow, blankDone  position strobes
module pixel_raster_cnt #(
  parameter int WIDTH       = 800,
  parameter int HEIGHT      = 600,
  parameter int HBLANK      = 4,
  parameter int FLUSH_LINES = 3
) (
  input  logic iclk,
  input  logic irst_n,
  input  logic clear,
  input  logic colStep,
  input  logic rowStep,
  input  logic rowClear,
  input  logic blankStep,
  input  logic flushMode,
  output logic lastCol,
  output logic lastRow,
  output logic blankDone
);

  localparam int ROW_MAX = (HEIGHT > FLUSH_LINES) ? HEIGHT : FLUSH_LINES;
  localparam int COL_W   = (WIDTH > 1)   ? $clog2(WIDTH)   : 1;
  localparam int ROW_W   = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;
  localparam int BLK_W   = (HBLANK > 1)  ? $clog2(HBLANK)  : 1;

  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(HEIGHT - 1);
  localparam logic [ROW_W-1:0] FLUSH_LAST = ROW_W'((FLUSH_LINES > 0) ? FLUSH_LINES - 1 : 0);
  localparam logic [BLK_W-1:0] BLK_LAST   = BLK_W'((HBLANK > 0) ? HBLANK - 1 : 0);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [BLK_W-1:0] blank;

  assign lastCol   = (col == COL_LAST);
  assign lastRow   = (row == (flushMode ? FLUSH_LAST : ROW_LAST));
  assign blankDone = (blank == BLK_LAST);

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      col   <= '0;
      row   <= '0;
      blank <= '0;
    end else if (clear) begin
      col   <= '0;
      row   <= '0;
      blank <= '0;
    end else begin
      if (colStep) col <= lastCol ? '0 : col + 1'b1;
      if (rowClear) begin
        row   <= '0;
        blank <= '0;
      end else if (rowStep) begin
        row   <= row + 1'b1;
        blank <= '0;
      end else if (blankStep) begin
        blank <= blank + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// Frame-buffer reader: on istart reads one WIDTH x HEIGHT frame in raster
// order from a 1-cycle-latency synchronous RAM and streams it as
// {1'b1, pixel}; idle and blank cycles carry 9'h000.
// Ports:
//   iclk, irst_n  clock, asynchronous active-low reset
//   istart        start a frame (ignored unless idle)
//   ipause        downstream stall, blocks new reads
//   bus           RAM read port and output stream (pixel_stream_tx_if.master)
//   obusy         frame in progress
//   odone         one-cycle pulse after the final word
// Build option PIXEL_TX_FLUSH_EN: append FLUSH_LINES lines of zero pixels
// after the frame so the downstream kernel can finish the bottom rows.
module pixel_stream_tx #(
  parameter int WIDTH       = 800,
  parameter int HEIGHT      = 600,
  parameter int ADDR_W      = 19,
  parameter int HBLANK      = 4,
  parameter int FLUSH_LINES = 3
) (
  input  logic              iclk,
  input  logic              irst_n,
  input  logic              istart,
  input  logic              ipause,
  pixel_stream_tx_if.master bus,
  output logic              obusy,
  output logic              odone
);
  import sift_pkg::*;

  function automatic logic [STREAM_W-1:0] streamWord(input logic vld, input logic flush,
                                                     input logic [PIX_W-1:0] pix);
    logic [STREAM_W-1:0] w;
    w = '0;
    if (vld) begin
      w[VALID_BIT] = 1'b1;
      if (!flush) w[PIX_W-1:0] = pix;
    end
    return w;
  endfunction

  tx_state_t state, nextState;
  logic              inFlush;
  logic [ADDR_W-1:0] addr;

  logic issue, isFlush, lend, fend, addrInc, setFlush;
  logic clear, colStep, rowStep, rowClear, blankStep;
  logic lastCol, lastRow, blankDone;

  logic vld_p0, flush_p0, lend_p0, fend_p0;
  logic vld_p1, flush_p1, lend_p1, fend_p1;

  pixel_raster_cnt #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .HBLANK(HBLANK), .FLUSH_LINES(FLUSH_LINES)
  ) raster (
    .iclk(iclk), .irst_n(irst_n), .clear(clear), .colStep(colStep),
    .rowStep(rowStep), .rowClear(rowClear), .blankStep(blankStep),
    .flushMode(inFlush), .lastCol(lastCol), .lastRow(lastRow), .blankDone(blankDone)
  );

  always_comb begin
    nextState = state;
    issue     = 1'b0;
    isFlush   = 1'b0;
    lend      = 1'b0;
    fend      = 1'b0;
    addrInc   = 1'b0;
    setFlush  = 1'b0;
    clear     = 1'b0;
    colStep   = 1'b0;
    rowStep   = 1'b0;
    rowClear  = 1'b0;
    blankStep = 1'b0;
    case (state)
      IDLE: begin
        if (istart) begin
          nextState = ACTIVE;
          clear     = 1'b1;
        end
      end
      ACTIVE: begin
        if (!ipause) begin
          issue   = 1'b1;
          colStep = 1'b1;
          lend    = lastCol;
          // The address stops on the final pixel instead of running past the frame.
          addrInc = !(lastCol && lastRow);
          if (lastCol) begin
            if (lastRow) begin
`ifdef PIXEL_TX_FLUSH_EN
              if (HBLANK > 0) begin
                nextState = sift_pkg::HBLANK;
              end else begin
                nextState = FLUSH;
                rowClear  = 1'b1;
                setFlush  = 1'b1;
              end
`else
              fend      = 1'b1;
              nextState = DRAIN;
`endif
            end else if (HBLANK > 0) begin
              nextState = sift_pkg::HBLANK;
            end else begin
              rowStep = 1'b1;
            end
          end
        end
      end
      sift_pkg::HBLANK: begin
        if (!ipause) begin
          blankStep = 1'b1;
          if (blankDone) begin
`ifdef PIXEL_TX_FLUSH_EN
            if (inFlush) begin
              nextState = FLUSH;
              rowStep   = 1'b1;
            end else if (lastRow) begin
              // Blank after the last frame line leads into the flush lines.
              nextState = FLUSH;
              rowClear  = 1'b1;
              setFlush  = 1'b1;
            end else begin
              nextState = ACTIVE;
              rowStep   = 1'b1;
            end
`else
            nextState = ACTIVE;
            rowStep   = 1'b1;
`endif
          end
        end
      end
`ifdef PIXEL_TX_FLUSH_EN
      FLUSH: begin
        if (!ipause) begin
          issue   = 1'b1;
          isFlush = 1'b1;
          colStep = 1'b1;
          lend    = lastCol;
          if (lastCol) begin
            if (lastRow) begin
              fend      = 1'b1;
              nextState = DRAIN;
            end else if (HBLANK > 0) begin
              nextState = sift_pkg::HBLANK;
            end else begin
              rowStep = 1'b1;
            end
          end
        end
      end
`endif
      DRAIN: begin
        if (!vld_p0 && !vld_p1) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      state          <= IDLE;
      inFlush        <= 1'b0;
      addr           <= '0;
      bus.omem_rd    <= 1'b0;
      bus.omem_addr  <= '0;
      vld_p0         <= 1'b0;
      flush_p0       <= 1'b0;
      lend_p0        <= 1'b0;
      fend_p0        <= 1'b0;
      vld_p1         <= 1'b0;
      flush_p1       <= 1'b0;
      lend_p1        <= 1'b0;
      fend_p1        <= 1'b0;
      bus.oPixelData <= '0;
      bus.oline_end  <= 1'b0;
      bus.oframe_end <= 1'b0;
      obusy          <= 1'b0;
      odone          <= 1'b0;
    end else begin
      state <= nextState;
      if (clear) begin
        inFlush <= 1'b0;
        addr    <= '0;
      end else begin
        if (setFlush) inFlush <= 1'b1;
        if (issue && !isFlush && addrInc) addr <= addr + 1'b1;
      end

      // p0: read strobe registered; flush words ride the same slot without a read
      bus.omem_rd <= issue && !isFlush;
      if (issue && !isFlush) bus.omem_addr <= addr;
      vld_p0   <= issue;
      flush_p0 <= isFlush;
      lend_p0  <= lend;
      fend_p0  <= fend;

      // p1: RAM is returning data for the p0 read
      vld_p1   <= vld_p0;
      flush_p1 <= flush_p0;
      lend_p1  <= lend_p0;
      fend_p1  <= fend_p0;

      // output: capture RAM data with its markers
      bus.oPixelData <= streamWord(vld_p1, flush_p1, bus.imem_data);
      bus.oline_end  <= vld_p1 && lend_p1;
      bus.oframe_end <= vld_p1 && fend_p1;

      obusy <= (nextState == ACTIVE) || (nextState == sift_pkg::HBLANK) ||
               (nextState == FLUSH)  || (nextState == DRAIN);
      odone <= (nextState == DONE);
    end
  end

endmodule
